// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its two-requester arbiter.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOP = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// 4-bit combinational ALU: ADD, SUB, AND, OR; all other opcodes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] y_o
);

  // Carry and borrow fall off the top: results wrap modulo 2^ALU_W.
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; registers operands,
// evaluates for one cycle and holds a tagged result on a backpressured output.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ALU_W-1:0] res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q;
  logic [OP_W-1:0]  op_q;
  logic [ALU_W-1:0] a_q, b_q;
  logic             id_q;
  logic [ALU_W-1:0] res_data_q;
  logic             res_id_q;
  logic             res_zero_q;

  logic             grant;
  logic             window;
  logic             accept;
  logic [ALU_W-1:0] alu_y;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // rst_n gates the window so both readies read 0 while reset is held.
  assign window = rst_n && ((state_q == IDLE) || ((state_q == DONE) && res_ready));
  assign accept = window && (req0_valid || req1_valid);

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (res_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  alu u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant;
        id_q         <= grant;
        op_q         <= grant ? req1_op : req0_op;
        a_q          <= grant ? req1_a  : req0_a;
        b_q          <= grant ? req1_b  : req0_b;
      end
      if (state_q == EXEC) begin
        res_data_q <= alu_y;
        res_id_q   <= id_q;
        res_zero_q <= (alu_y == '0);
      end
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_zero  = res_zero_q;
  assign busy      = (state_q != IDLE);

endmodule
